// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Quotient goes to LO and remainder to HI. stall_req_o holds the pipeline while busy, and done_o pulses when the result is ready.
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  start_i,
  input  logic                  is_signed_i,
  input  logic [DATA_WIDTH-1:0] operand_1_i,
  input  logic [DATA_WIDTH-1:0] operand_2_i,
  output logic                  stall_req_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  rem_q, dvd_q, dvs_q, op1_q, quo_q, rmd_q;
  logic          qneg_q, rneg_q, dz_q;
  logic          s1, s2;
  logic [W-1:0]  abs1, abs2, rem_d, dvd_d, quo_d, rmd_d;
  logic [W:0]    trial;
  always_comb begin
    s1 = is_signed_i & operand_1_i[W-1];
    s2 = is_signed_i & operand_2_i[W-1];
    abs1 = s1 ? -operand_1_i : operand_1_i;
    abs2 = s2 ? -operand_2_i : operand_2_i;
    // Remainder stays below the divisor, so W+1 bits are enough to hold the trial's sign.
    trial = {rem_q, dvd_q[W-1]} - {1'b0, dvs_q};
    rem_d = trial[W] ? {rem_q[W-2:0], dvd_q[W-1]} : trial[W-1:0];
    dvd_d = {dvd_q[W-2:0], ~trial[W]};
    quo_d = dz_q ? '1 : qneg_q ? -dvd_d : dvd_d;
    rmd_d = dz_q ? op1_q : rneg_q ? -rem_d : rem_d;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      op1_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= CALC;
          cnt_q   <= '0;
          rem_q   <= '0;
          dvd_q   <= abs1;
          dvs_q   <= abs2;
          op1_q   <= operand_1_i;
          qneg_q  <= s1 ^ s2;
          rneg_q  <= s1;
          dz_q    <= operand_2_i == '0;
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            state_q <= DONE;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign done_o      = (state_q == DONE) & ~flush_i;
  assign stall_req_o = rst_ni & ~flush_i & (((state_q == IDLE) & start_i) | (state_q == CALC));
  assign quotient_o  = quo_q;
  assign remainder_o = rmd_q;
endmodule
